// File: rtl/fact_sequencer.sv
// fact_sequencer: iterative n! via shared multiplier req/ack handshake, one-cycle fact_end pulse
module fact_sequencer #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   operand,
  output logic           mul_req,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic           mul_ack,
  input  logic [2*W-1:0] mul_result,
  output logic [W-1:0]   result,
  output logic           overflow,
  output logic           fact_end,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, CHECK, MUL, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, cnt;
  logic high_nz;
  assign high_nz = |mul_result[2*W-1:W];
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= W'(1);
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        cnt      <= operand;
        acc      <= W'(1);
        overflow <= 1'b0;
      end
      // MUL is only entered with cnt >= 2, so the decrement cannot wrap
      if (state == MUL && mul_ack) begin
        acc <= mul_result[W-1:0];
        cnt <= cnt - W'(1);
        if (high_nz) overflow <= 1'b1;
      end
    end
  end
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = CHECK;
      CHECK: state_n = (cnt <= W'(1)) ? DONE : MUL;
      MUL:   if (mul_ack) state_n = high_nz ? DONE : CHECK;
      DONE:  state_n = IDLE;
    endcase
  end
  assign mul_req  = state == MUL;
  assign mul_a    = acc;
  assign mul_b    = cnt;
  assign result   = acc;
  assign fact_end = state == DONE;
  assign busy     = state != IDLE;
endmodule

// File: tb/tb_fact_sequencer.sv
// tb_fact_sequencer: scoreboard bench with a variable-latency multiplier model
module tb_fact_sequencer;
  logic        clk, rst, start, mul_req, mul_ack, overflow, fact_end, busy;
  logic [15:0] operand, mul_a, mul_b, result;
  logic [31:0] mul_result;
  int checks = 0, errors = 0, ack_dly = 0, wcnt = 0;

  fact_sequencer #(.W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .operand(operand),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack),
    .mul_result(mul_result), .result(result), .overflow(overflow),
    .fact_end(fact_end), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mul_ack    = mul_req && (wcnt == ack_dly);
  assign mul_result = {16'b0, mul_a} * {16'b0, mul_b};
  always @(posedge clk) wcnt <= (mul_req && !mul_ack) ? wcnt + 1 : 0;

  task automatic run_fact(input logic [15:0] n, input int dly, input logic [15:0] er,
                          input logic eo, input int pulse_at, input string name);
    logic [31:0] q[$];
    logic [31:0] p, e;
    logic [15:0] a, c, pa, pb;
    logic ovf, hold, done;
    int mults, el, cyc;
    a = 16'd1; c = n; ovf = 1'b0; mults = 0;
    while (c >= 16'd2 && !ovf) begin
      q.push_back({a, c});
      p = {16'b0, a} * {16'b0, c};
      a = p[15:0];
      c = c - 16'd1;
      mults++;
      ovf = |p[31:16];
    end
    el = mults * (2 + dly) + (ovf ? 0 : 1) + 1;
    ack_dly = dly;
    @(negedge clk); operand = n; start = 1'b1;
    @(negedge clk); start = 1'b0; operand = 16'd2;
    cyc = 1; hold = 1'b0; done = 1'b0; pa = '0; pb = '0;
    while (!done && cyc < 400) begin
      if (hold && mul_req) begin
        checks++;
        if ({mul_a, mul_b} !== {pa, pb}) begin
          errors++;
          $display("FAIL %s stable: got a=%0d b=%0d want a=%0d b=%0d", name, mul_a, mul_b, pa, pb);
        end
      end
      if (mul_req && mul_ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_handshake: got a=%0d b=%0d want none", name, mul_a, mul_b);
        end else begin
          e = q.pop_front();
          if ({mul_a, mul_b} !== e) begin
            errors++;
            $display("FAIL %s handshake: got a=%0d b=%0d want a=%0d b=%0d", name, mul_a, mul_b, e[31:16], e[15:0]);
          end
        end
        hold = 1'b0;
      end else begin
        hold = mul_req; pa = mul_a; pb = mul_b;
      end
      if (fact_end) done = 1'b1;
      else begin
        start = (cyc == pulse_at);
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: got no fact_end want fact_end", name); end
    checks++;
    if (cyc != el) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, cyc, el); end
    checks++;
    if (result !== er) begin errors++; $display("FAIL %s result: got %h want %h", name, result, er); end
    checks++;
    if (overflow !== eo) begin errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, eo); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL %s missing_handshakes: got %0d left want 0", name, q.size()); end
    @(negedge clk);
    checks++;
    if ({fact_end, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s after_done: got fact_end=%b busy=%b want 0 0", name, fact_end, busy);
    end
    checks++;
    if (result !== er || overflow !== eo) begin
      errors++;
      $display("FAIL %s hold: got %h/%b want %h/%b", name, result, overflow, er, eo);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({state_ok(), mul_req, busy, fact_end, overflow} !== 5'b10000 || result !== 16'd1 ||
        mul_a !== 16'd1 || mul_b !== 16'd0) begin
      errors++;
      $display("FAIL %s: got req=%b busy=%b end=%b ovf=%b res=%h a=%h b=%h want 0 0 0 0 0001 0001 0000",
               name, mul_req, busy, fact_end, overflow, result, mul_a, mul_b);
    end
  endtask

  function automatic logic state_ok();
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; operand = 16'd5;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset_with_start");
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_zero_one();
    run_fact(16'd0, 0, 16'd1, 1'b0, -1, "n0");
    run_fact(16'd1, 0, 16'd1, 1'b0, -1, "n1");
  endtask

  task automatic test_fact5();
    run_fact(16'd5, 0, 16'h0078, 1'b0, -1, "n5");
  endtask

  task automatic test_fact8_wait();
    run_fact(16'd8, 3, 16'h9D80, 1'b0, -1, "n8_wait");
  endtask

  task automatic test_overflow();
    run_fact(16'd9, 0, 16'hC4C0, 1'b1, -1, "n9_ovf");
    run_fact(16'd3, 1, 16'd6, 1'b0, -1, "n3_clear");
  endtask

  task automatic test_back_to_back();
    run_fact(16'd5, 0, 16'd120, 1'b0, 3, "n5_restart_ignored");
    run_fact(16'd5, 2, 16'd120, 1'b0, 4, "n5_restart_wait");
  endtask

  task automatic test_reset_mid();
    int n;
    ack_dly = 3;
    @(negedge clk); operand = 16'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!mul_req && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (!mul_req) begin errors++; $display("FAIL reset_mid reach_mul: got req=0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_mid");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({fact_end, busy, mul_req} !== 3'b000) begin
        errors++;
        $display("FAIL reset_mid idle: got end=%b busy=%b req=%b want 0 0 0", fact_end, busy, mul_req);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; operand = '0;
    test_reset();
    test_zero_one();
    test_fact5();
    test_fact8_wait();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    run_fact(16'd4, 0, 16'd24, 1'b0, -1, "n4_after_reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
